fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage for the single-cycle RISC-V core. Owns the program counter, fetches instructions over a valid/ready request and valid-only response interface, and holds each instruction stable while the core executes it. Decodes `op`, `funct3` and `funct7_5` straight from the held instruction to feed the control unit. Consumes `PCSrc` and the branch/jump targets on retire to form the next PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Must be 4-byte aligned.
- `clk`  in  1  core clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `imem_req_valid`  out  1  fetch request pending
- `imem_req_ready`  in  1  memory accepts request
- `imem_addr`  out  32  fetch address; equals `pc`
- `imem_rsp_valid`  in  1  `imem_rdata` valid this cycle
- `imem_rdata`  in  32  fetched instruction word
- `instr`  out  32  held instruction
- `instr_valid`  out  1  `instr` is valid and executing
- `op`  out  7  `instr[6:0]`
- `funct3`  out  3  `instr[14:12]`
- `funct7_5`  out  1  `instr[30]`
- `pc`  out  32  address of the current instruction
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32
- `PCSrc`  in  2  next-PC select: 00 = pc+4, 01 = `PCTarget`, 10 = `ALUResult & ~1`, 11 = pc+4
- `PCTarget`  in  32  branch/JAL target
- `ALUResult`  in  32  JALR target
- `retire`  in  1  current instruction completes this cycle
- `fetch_fault`  out  1  misaligned next-PC trap, sticky until reset
- `instret`  out  32  retired-instruction count

## Operation
- FSM states are REQ, WAIT, EXEC and FAULT.
- Reset forces REQ, `pc`=`RESET_PC`, `instr`=32'h0000_0013 (NOP), `instret`=0 and `fetch_fault`=0.
- **REQ**
  - `imem_req_valid`=1.
  - On `imem_req_ready`=1, go to WAIT.
  - `imem_rsp_valid` in REQ is ignored.
- **WAIT**
  - `imem_req_valid`=0.
  - On `imem_rsp_valid`=1, latch `imem_rdata` into `instr` and go to EXEC.
  - Otherwise stay in WAIT indefinitely (no timeout).
- **EXEC**
  - `instr_valid`=1.
  - On `retire`=1, compute next PC from `PCSrc`, then:
    - If next PC bits [1:0] are nonzero: go to FAULT, `fetch_fault`=1, `pc` unchanged, `instret` still increments.
    - Otherwise: `pc` takes the next PC, `instret`+1, go to REQ.
  - `PCSrc`, `PCTarget` and `ALUResult` are sampled only in the retire cycle.
- **FAULT**
  - Terminal. No requests; `instr_valid`=0; `instr` and `pc` hold.
  - Only `rst` exits.
- `retire` outside EXEC is ignored; no state, `pc` or `instret` change.
- `imem_rsp_valid` in EXEC or FAULT is ignored; `instr` is not overwritten.
- Arithmetic:
  - `pc_plus4` and `instret` wrap modulo 2^32.
  - 32'hFFFF_FFFC + 4 = 32'h0000_0000 with no fault.
  - `instret` 32'hFFFF_FFFF wraps to 0.
- `op`, `funct3` and `funct7_5` are combinational slices of `instr` and valid whenever `instr_valid`=1.

## Timing
- Outputs are registered state or combinational functions of state and `instr`/`pc`.
- No combinational path from `imem_*` inputs to outputs.
- Reset:
  - In the cycle `rst` is sampled high and the cycle after, `imem_req_valid`=0.
  - The first request is asserted in the cycle after `rst` deasserts (REQ entered at that edge).
  - During reset, `instr_valid`=0 and `fetch_fault`=0.
- Request hold: while `imem_req_valid`=1, `imem_addr` is stable until the handshake cycle.
- Minimum latency: request accepted in cycle N, response in cycle N+1, `instr_valid`=1 in cycle N+2.
- Retire in cycle M:
  - `pc`, `instret` and state update at the end of M.
  - The next `imem_req_valid`=1 is in M+1.
  - `instr_valid`=0 from M+1 until the next response is latched.
- Best-case throughput is 1 instruction per 3 cycles.
- Reset mid-operation (WAIT or EXEC) returns to REQ at `RESET_PC`.
- The memory is reset with the core; a stale response is not expected after reset.

## Test plan
- **Reset and first fetch:** `RESET_PC`=0x100; deassert `rst`.
  - Next cycle: `imem_req_valid`=1, `imem_addr`=0x100, `instret`=0, `instr`=0x13.
- **Back-pressure:** hold `imem_req_ready`=0 for 5 cycles.
  - `imem_req_valid` and `imem_addr` stay stable.
  - Ready in cycle N, rsp 0x00500093 in N+1 → `instr_valid`=1 in N+2 with `op`=0x13, `funct3`=0, `funct7_5`=0.
- **Sequential retire:** retire with `PCSrc`=00 at `pc`=0x100 → next request address 0x104, `instret`=1.
- **Branch and JALR:**
  - `PCSrc`=01, `PCTarget`=0x200 → fetch 0x200.
  - `PCSrc`=10, `ALUResult`=0x301 → fetch 0x300.
- **Misaligned target:** `PCSrc`=01, `PCTarget`=0x202 → `fetch_fault`=1, no further `imem_req_valid`, `instret` incremented; assert `rst` → state REQ, fault cleared.
- **Ignored events:**
  - `retire` while in WAIT causes no change.
  - Spurious `imem_rsp_valid` in EXEC leaves `instr` unchanged.
  - `pc`=0xFFFFFFFC retire with `PCSrc`=00 → fetch 0x0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, imem request/response sequencing, instruction hold and next-PC selection
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7_5,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] PCTarget,
    input  logic [31:0] ALUResult,
    input  logic        retire,
    output logic        fetch_fault,
    output logic [31:0] instret
);
    typedef enum logic [1:0] {REQ, WAIT, EXEC, FAULT} state_t;
    state_t state;
    logic [31:0] next_pc;
    assign imem_addr = pc;
    assign pc_plus4 = pc + 32'd4;
    assign op = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7_5 = instr[30];
    always_comb next_pc = PCSrc == 2'b01 ? PCTarget : PCSrc == 2'b10 ? (ALUResult & ~32'd1) : pc_plus4;
    // req_valid is registered, so REQ after reset spends one cycle raising it
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REQ;
            pc <= RESET_PC;
            instr <= 32'h0000_0013;
            instret <= '0;
            fetch_fault <= 1'b0;
            imem_req_valid <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (imem_req_valid && imem_req_ready) begin
                        state <= WAIT;
                        imem_req_valid <= 1'b0;
                    end else
                        imem_req_valid <= 1'b1;
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        instr <= imem_rdata;
                        instr_valid <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (retire) begin
                        instret <= instret + 32'd1;
                        instr_valid <= 1'b0;
                        if (|next_pc[1:0]) begin
                            state <= FAULT;
                            fetch_fault <= 1'b1;
                        end else begin
                            pc <= next_pc;
                            state <= REQ;
                            imem_req_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
